// File: rtl/pe_array_sched_if.sv
// rtl/pe_array_sched_if.sv - command, memory and PE_Array bus bundle for pe_array_sched
//
// Groups every pe_array_sched signal except clk/rst.
//   slave  : the scheduler side (pe_array_sched)
//   master : the surrounding system (control FSM, operand/result memories, PE_Array)
// Signals:
//   cmd_valid/cmd_ready, cmd_instr, cmd_alg, cmd_src, cmd_dst, cmd_len : job command
//   busy, done                           : job status
//   rd_en, rd_addr, rd_data              : operand memory (rd_data valid the cycle after rd_en)
//   pe_instr, pe_alg, pe_data_in         : to PE_Array
//   pe_data_out                          : from PE_Array
//   wr_en, wr_addr, wr_data              : result memory
interface pe_array_sched_if #(
    parameter int WIDTH   = 24,
    parameter int NUM     = 4,
    parameter int IN_NUM  = 3,
    parameter int OUT_NUM = 2,
    parameter int ADDR_W  = 8,
    parameter int LEN_W   = 9
);
    logic                          cmd_valid;
    logic                          cmd_ready;
    logic [4:0]                    cmd_instr;
    logic [4:0]                    cmd_alg;
    logic [ADDR_W-1:0]             cmd_src;
    logic [ADDR_W-1:0]             cmd_dst;
    logic [LEN_W-1:0]              cmd_len;
    logic                          busy;
    logic                          done;
    logic                          rd_en;
    logic [ADDR_W-1:0]             rd_addr;
    logic [NUM*IN_NUM*WIDTH-1:0]   rd_data;
    logic [4:0]                    pe_instr;
    logic [4:0]                    pe_alg;
    logic [NUM*IN_NUM*WIDTH-1:0]   pe_data_in;
    logic [NUM*OUT_NUM*WIDTH-1:0]  pe_data_out;
    logic                          wr_en;
    logic [ADDR_W-1:0]             wr_addr;
    logic [NUM*OUT_NUM*WIDTH-1:0]  wr_data;

    modport slave (
        input  cmd_valid, cmd_instr, cmd_alg, cmd_src, cmd_dst, cmd_len,
        input  rd_data, pe_data_out,
        output cmd_ready, busy, done,
        output rd_en, rd_addr,
        output pe_instr, pe_alg, pe_data_in,
        output wr_en, wr_addr, wr_data
    );

    modport master (
        output cmd_valid, cmd_instr, cmd_alg, cmd_src, cmd_dst, cmd_len,
        output rd_data, pe_data_out,
        input  cmd_ready, busy, done,
        input  rd_en, rd_addr,
        input  pe_instr, pe_alg, pe_data_in,
        input  wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/pe_array_sched.sv
// rtl/pe_array_sched.sv - job sequencer streaming operand vectors through PE_Array
//
// Accepts one vector command, reads len operand vectors (one per cycle) from a
// synchronous operand memory, feeds them to PE_Array, follows the array's fixed
// LAT-cycle latency with a valid shift register and writes each result back.
// Ports:
//   clk  : clock, all state on rising edge
//   rst  : asynchronous active-low reset
//   bus  : pe_array_sched_if.slave (command, status, memories, PE_Array)
module pe_array_sched #(
    parameter int WIDTH   = 24,
    parameter int NUM     = 4,
    parameter int IN_NUM  = 3,
    parameter int OUT_NUM = 2,
    parameter int LAT     = 4,
    parameter int ADDR_W  = 8,
    parameter int LEN_W   = 9
) (
    input  logic              clk,
    input  logic              rst,
    pe_array_sched_if.slave   bus
);
    localparam int IN_W  = NUM * IN_NUM * WIDTH;
    localparam int OUT_W = NUM * OUT_NUM * WIDTH;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } state_t;

    state_t            state;
    state_t            state_n;

    logic [4:0]        instr_q;
    logic [4:0]        alg_q;
    logic [ADDR_W-1:0] src_q;
    logic [ADDR_W-1:0] dst_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  issue_cnt;
    logic [LEN_W-1:0]  retire_cnt;

    // vld[0]: operand at PE input this cycle; vld[LAT]: result at PE output.
    logic [LAT:0]      vld;

    logic              accept;
    logic              rd_go;
    logic              wr_go;
    logic              cmd_ready_c;
    logic              busy_c;
    logic              done_c;

    assign wr_go = vld[LAT];

    always_comb begin
        state_n     = state;
        cmd_ready_c = 1'b0;
        busy_c      = 1'b0;
        done_c      = 1'b0;
        rd_go       = 1'b0;
        accept      = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready_c = 1'b1;
                if (bus.cmd_valid) begin
                    accept  = 1'b1;
                    state_n = (bus.cmd_len == '0) ? FIN : ISSUE;
                end
            end
            ISSUE: begin
                busy_c = 1'b1;
                rd_go  = 1'b1;
                if (issue_cnt == len_q - LEN_W'(1)) begin
                    state_n = DRAIN;
                end
            end
            DRAIN: begin
                busy_c = 1'b1;
                // Since LAT >= 1 the last write always lands in DRAIN, never ISSUE.
                if (wr_go && (retire_cnt == len_q - LEN_W'(1))) begin
                    state_n = FIN;
                end
            end
            FIN: begin
                busy_c  = 1'b1;
                done_c  = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Job registers: instr/alg stay latched until the next accepted command so
    // the array never sees an instruction change while results are in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            instr_q    <= '0;
            alg_q      <= '0;
            src_q      <= '0;
            dst_q      <= '0;
            len_q      <= '0;
            issue_cnt  <= '0;
            retire_cnt <= '0;
        end else begin
            if (accept) begin
                instr_q    <= bus.cmd_instr;
                alg_q      <= bus.cmd_alg;
                src_q      <= bus.cmd_src;
                dst_q      <= bus.cmd_dst;
                len_q      <= bus.cmd_len;
                issue_cnt  <= '0;
                retire_cnt <= '0;
            end else begin
                if (rd_go) begin
                    issue_cnt <= issue_cnt + LEN_W'(1);
                end
                if (wr_go) begin
                    retire_cnt <= retire_cnt + LEN_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld <= '0;
        end else begin
            vld <= {vld[LAT-1:0], rd_go};
        end
    end

    assign bus.cmd_ready  = cmd_ready_c;
    assign bus.busy       = busy_c;
    assign bus.done       = done_c;

    // Addresses wrap naturally through truncation to ADDR_W bits.
    assign bus.rd_en      = rd_go;
    assign bus.rd_addr    = rd_go ? (src_q + ADDR_W'(issue_cnt)) : '0;

    assign bus.pe_instr   = instr_q;
    assign bus.pe_alg     = alg_q;
    assign bus.pe_data_in = vld[0] ? bus.rd_data : {IN_W{1'b0}};

    assign bus.wr_en      = wr_go;
    assign bus.wr_addr    = wr_go ? (dst_q + ADDR_W'(retire_cnt)) : '0;
    assign bus.wr_data    = wr_go ? bus.pe_data_out : {OUT_W{1'b0}};
endmodule
